// File: rtl/rob_multi_ins.sv
// Reorder buffer indexed by sequence number: out-of-order inserts on p_num_ins ports, in-order commit.
// Head is combinational (bypass 0 cycles, stored entry 1 cycle); a busy slot rejects its insert, and flush overrides everything.
module rob_multi_ins #(
  parameter int p_depth     = 8,
  parameter int p_num_ins   = 2,
  parameter int p_data_bits = 70
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [p_num_ins-1:0]             ins_en,
  input  logic [$clog2(p_depth)-1:0]       ins_seq_num [p_num_ins],
  input  logic [p_data_bits-1:0]           ins_data    [p_num_ins],
  output logic [p_num_ins-1:0]             ins_rdy,
  input  logic                             deq_front_en,
  output logic                             deq_front_rdy,
  output logic [p_data_bits-1:0]           deq_front_data,
  output logic [$clog2(p_depth)-1:0]       deq_front_seq_num,
  input  logic                             flush_en,
  input  logic [$clog2(p_depth)-1:0]       flush_seq_num,
  output logic [$clog2(p_depth+1)-1:0]     count
);

  localparam int SW = $clog2(p_depth);
  localparam int CW = $clog2(p_depth + 1);

  logic [p_depth-1:0]     occ;
  logic [p_data_bits-1:0] data_q [p_depth];
  logic [SW-1:0]          deq_ptr;

  logic [p_num_ins-1:0]   grant;
  logic [p_num_ins-1:0]   bp_oh;
  logic [p_num_ins-1:0]   store;
  logic [p_data_bits-1:0] bp_data;
  logic                   found;
  logic                   head_occ;
  logic                   bypass;
  logic                   commit;
  logic                   consumed;
  logic [CW-1:0]          count_nxt;

  always_comb begin
    grant    = '0;
    bp_oh    = '0;
    bp_data  = '0;
    found    = 1'b0;
    head_occ = occ[deq_ptr];
    for (int k = 0; k < p_num_ins; k++) begin
      grant[k] = rst && ins_en[k] && !flush_en && !occ[ins_seq_num[k]];
      // A lower port requesting the same slot wins, even if it was itself rejected.
      for (int j = 0; j < k; j++) begin
        if (ins_en[j] && (ins_seq_num[j] == ins_seq_num[k])) grant[k] = 1'b0;
      end
      // Only the lowest-index granted port is a bypass candidate.
      if (grant[k] && !found) begin
        found = 1'b1;
        if ((ins_seq_num[k] == deq_ptr) && !head_occ) begin
          bp_oh[k] = 1'b1;
          bp_data  = ins_data[k];
        end
      end
    end

    bypass         = |bp_oh;
    deq_front_rdy  = !flush_en && (head_occ || bypass);
    deq_front_data = head_occ ? data_q[deq_ptr] : bp_data;
    commit         = deq_front_en && deq_front_rdy;
    consumed       = commit && !head_occ;
    store          = consumed ? (grant & ~bp_oh) : grant;

    count_nxt = count;
    for (int k = 0; k < p_num_ins; k++) begin
      if (store[k]) count_nxt = count_nxt + CW'(1);
    end
    if (commit && head_occ) count_nxt = count_nxt - CW'(1);
  end

  assign ins_rdy           = grant;
  assign deq_front_seq_num = deq_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ     <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else if (flush_en) begin
      occ     <= '0;
      deq_ptr <= flush_seq_num;
      count   <= '0;
    end else begin
      for (int k = 0; k < p_num_ins; k++) begin
        if (store[k]) occ[ins_seq_num[k]] <= 1'b1;
      end
      if (commit) begin
        occ[deq_ptr] <= 1'b0;
        deq_ptr      <= deq_ptr + SW'(1);
      end
      count <= count_nxt;
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    for (int k = 0; k < p_num_ins; k++) begin
      if (store[k]) data_q[ins_seq_num[k]] <= ins_data[k];
    end
  end

endmodule

// File: tb/tb_rob_multi_ins.sv
// Directed bench for rob_multi_ins; expected commits queue up and a negedge monitor checks each commit.
module tb_rob_multi_ins;

  logic        clk;
  logic        rst;
  logic [1:0]  ins_en;
  logic [2:0]  ins_seq_num [2];
  logic [69:0] ins_data    [2];
  logic [1:0]  ins_rdy;
  logic        deq_front_en;
  logic        deq_front_rdy;
  logic [69:0] deq_front_data;
  logic [2:0]  deq_front_seq_num;
  logic        flush_en;
  logic [2:0]  flush_seq_num;
  logic [3:0]  count;

  typedef struct packed {
    logic [2:0]  seq;
    logic [69:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  rob_multi_ins #(.p_depth(8), .p_num_ins(2), .p_data_bits(70)) dut (
    .clk              (clk),
    .rst              (rst),
    .ins_en           (ins_en),
    .ins_seq_num      (ins_seq_num),
    .ins_data         (ins_data),
    .ins_rdy          (ins_rdy),
    .deq_front_en     (deq_front_en),
    .deq_front_rdy    (deq_front_rdy),
    .deq_front_data   (deq_front_data),
    .deq_front_seq_num(deq_front_seq_num),
    .flush_en         (flush_en),
    .flush_seq_num    (flush_seq_num),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [69:0] dat(input int p, input int s);
    return 70'h3A_0000_0000_0000_A000 + 70'(p * 256 + s);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit e0, input int s0, input bit e1, input int s1,
                       input bit de, input bit fl, input int fs);
    ins_en         = {e1, e0};
    ins_seq_num[0] = 3'(s0);
    ins_seq_num[1] = 3'(s1);
    ins_data[0]    = dat(0, s0);
    ins_data[1]    = dat(1, s1);
    deq_front_en   = de;
    flush_en       = fl;
    flush_seq_num  = 3'(fs);
  endtask

  task automatic idle(input bit de);
    drive(0, 0, 0, 0, de, 0, 0);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [69:0] d);
    exp_t e;
    e.seq = 3'(s);
    e.dat = d;
    exp_q.push_back(e);
  endtask

  // Commit monitor
  always @(negedge clk) begin
    if (rst && deq_front_en && deq_front_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got seq %0d data %0h want no commit",
                 deq_front_seq_num, deq_front_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_seq", 128'(deq_front_seq_num), 128'(e.seq));
        chk("commit_data", 128'(deq_front_data), 128'(e.dat));
      end
    end
  end

  initial begin
    rst = 1'b0;
    drive(1, 0, 1, 0, 1, 0, 0);
    #3;
    chk("rst_ins_rdy", 128'(ins_rdy), 128'(0));
    chk("rst_deq_rdy", 128'(deq_front_rdy), 128'(0));
    chk("rst_deq_data", 128'(deq_front_data), 128'(0));
    chk("rst_seq", 128'(deq_front_seq_num), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    adv();
    rst = 1'b1;

    // Out-of-order inserts 2,1,0 with commit held high
    push(0, dat(0, 0)); push(1, dat(0, 1)); push(2, dat(0, 2));
    drive(1, 2, 0, 0, 1, 0, 0); #3;
    chk("t1_rdy_s2", 128'(ins_rdy), 128'(2'b01));
    chk("t1_head_empty", 128'(deq_front_rdy), 128'(0));
    adv();
    drive(1, 1, 0, 0, 1, 0, 0); #3;
    chk("t1_rdy_s1", 128'(ins_rdy), 128'(2'b01));
    adv();
    drive(1, 0, 0, 0, 1, 0, 0); #3;
    chk("t1_bypass_rdy", 128'(deq_front_rdy), 128'(1));
    chk("t1_bypass_data", 128'(deq_front_data), 128'(dat(0, 0)));
    adv();
    idle(1); #3;
    chk("t1_count2", 128'(count), 128'(2));
    adv();
    adv();
    idle(0); #3;
    chk("t1_seq3", 128'(deq_front_seq_num), 128'(3));
    chk("t1_count0", 128'(count), 128'(0));
    chk("t1_empty", 128'(deq_front_rdy), 128'(0));
    adv();

    // Both ports target seq 4: port 0 wins
    drive(1, 4, 1, 4, 0, 0, 0); #3;
    chk("t2_conflict_rdy", 128'(ins_rdy), 128'(2'b01));
    adv();
    push(3, dat(0, 3)); push(4, dat(0, 4));
    drive(1, 3, 0, 0, 1, 0, 0); #3;
    chk("t2_count1", 128'(count), 128'(1));
    adv();
    idle(1);
    adv();
    idle(0); #3;
    chk("t2_count0", 128'(count), 128'(0));
    chk("t2_seq5", 128'(deq_front_seq_num), 128'(5));
    adv();

    // Insert at head with commit low: kept, then committed
    drive(1, 5, 0, 0, 0, 0, 0); #3;
    chk("t3_rdy", 128'(ins_rdy), 128'(2'b01));
    chk("t3_bp_head", 128'(deq_front_rdy), 128'(1));
    chk("t3_bp_data", 128'(deq_front_data), 128'(dat(0, 5)));
    adv();
    idle(0); #3;
    chk("t3_count1", 128'(count), 128'(1));
    chk("t3_stored_data", 128'(deq_front_data), 128'(dat(0, 5)));
    push(5, dat(0, 5));
    adv();
    idle(1);
    adv();
    idle(0); #3;
    chk("t3_count0", 128'(count), 128'(0));
    chk("t3_empty", 128'(deq_front_rdy), 128'(0));
    chk("t3_seq6", 128'(deq_front_seq_num), 128'(6));
    adv();

    // Fill all 8 slots, reject a 9th, then 8 commits wrapping the pointer
    drive(1, 6, 1, 7, 0, 0, 0); adv();
    drive(1, 0, 1, 1, 0, 0, 0); adv();
    drive(1, 2, 1, 3, 0, 0, 0); adv();
    drive(1, 4, 1, 5, 0, 0, 0); adv();
    drive(1, 3, 0, 0, 0, 0, 0); #3;
    chk("t4_full_count", 128'(count), 128'(8));
    chk("t4_full_reject", 128'(ins_rdy), 128'(0));
    chk("t4_full_head", 128'(deq_front_rdy), 128'(1));
    adv();
    for (int i = 0; i < 8; i++) begin
      int s;
      s = (6 + i) % 8;
      push(s, dat(s % 2, s));
    end
    drive(1, 6, 0, 0, 1, 0, 0); #3;
    chk("t4_commit_slot_reject", 128'(ins_rdy), 128'(0));
    adv();
    for (int i = 0; i < 7; i++) begin
      idle(1);
      adv();
    end
    idle(0); #3;
    chk("t4_count0", 128'(count), 128'(0));
    chk("t4_wrap_seq6", 128'(deq_front_seq_num), 128'(6));
    chk("t4_empty", 128'(deq_front_rdy), 128'(0));
    adv();

    // Flush with 5 pending entries
    drive(1, 7, 1, 0, 0, 0, 0); adv();
    drive(1, 1, 1, 2, 0, 0, 0); adv();
    drive(1, 3, 0, 0, 0, 0, 0); adv();
    idle(0); #3;
    chk("t5_count5", 128'(count), 128'(5));
    adv();
    drive(1, 6, 0, 0, 1, 1, 2); #3;
    chk("t5_flush_ins_rdy", 128'(ins_rdy), 128'(0));
    chk("t5_flush_deq_rdy", 128'(deq_front_rdy), 128'(0));
    adv();
    idle(0); #3;
    chk("t5_count0", 128'(count), 128'(0));
    chk("t5_seq2", 128'(deq_front_seq_num), 128'(2));
    chk("t5_squashed", 128'(deq_front_rdy), 128'(0));
    adv();
    push(2, dat(0, 2));
    drive(1, 2, 0, 0, 1, 0, 0); #3;
    chk("t5_bypass_rdy", 128'(deq_front_rdy), 128'(1));
    adv();
    idle(0); #3;
    chk("t5_squashed3", 128'(deq_front_rdy), 128'(0));
    chk("t5_seq3", 128'(deq_front_seq_num), 128'(3));
    adv();

    // Asynchronous reset mid-cycle with 3 pending
    drive(1, 3, 1, 4, 0, 0, 0); adv();
    drive(1, 5, 0, 0, 0, 0, 0); adv();
    idle(0); #3;
    chk("t6_count3", 128'(count), 128'(3));
    chk("t6_head", 128'(deq_front_rdy), 128'(1));
    rst = 1'b0;
    #1;
    chk("t6_async_count", 128'(count), 128'(0));
    chk("t6_async_rdy", 128'(deq_front_rdy), 128'(0));
    chk("t6_async_seq", 128'(deq_front_seq_num), 128'(0));
    chk("t6_async_data", 128'(deq_front_data), 128'(0));
    adv();
    rst = 1'b1;
    push(0, dat(0, 0));
    drive(1, 0, 0, 0, 1, 0, 0);
    adv();
    idle(0); #3;
    chk("t6_count0", 128'(count), 128'(0));
    chk("t6_seq1", 128'(deq_front_seq_num), 128'(1));
    adv();

    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_multi_ins.md
# rob_multi_ins

Parametrised reorder buffer for the writeback/commit stage with `p_num_ins` independent out-of-order insert ports, single in-order commit (dequeue) port, same-cycle insert-to-commit bypass, and a synchronous flush that squashes all pending entries and redirects the commit pointer. It sits between the execute-unit writeback arbiters and architectural-register commit. Entries are indexed directly by sequence number modulo `p_depth`.

## Interface

- Reset: one clock; reset is asynchronous and active-low.

Parameters:
- `p_depth`, 8: number of entries; power of two, ≥ 2. `SW` = `$clog2(p_depth)` is the sequence-number width.
- `p_num_ins`, 2: number of insert ports, ≥ 1.
- `p_data_bits`, 70: payload width (pc, waddr, wdata, wen packed).

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous reset, asserted low.
- `ins_en[p_num_ins]` in 1 each: insert request.
- `ins_seq_num[p_num_ins]` in `SW` each: target slot.
- `ins_data[p_num_ins]` in `p_data_bits` each: payload.
- `ins_rdy[p_num_ins]` out 1 each: insert accepted this cycle.
- `deq_front_en` in 1: commit request.
- `deq_front_rdy` out 1: head entry valid.
- `deq_front_data` out `p_data_bits`: head payload.
- `deq_front_seq_num` out `SW`: current commit pointer.
- `flush_en` in 1: squash all entries.
- `flush_seq_num` in `SW`: new commit pointer after flush.
- `count` out `$clog2(p_depth+1)`: number of occupied stored entries.

## Operation

- State: `occ[p_depth]`, `data[p_depth]`, `deq_ptr` (`SW` bits, wraps modulo `p_depth`), `count`.
- Only `occ`, `deq_ptr`, and `count` are reset. `data` is not reset.
- **Insert acceptance.** Port *k* is granted when all of the following hold:
  - `ins_en[k]` is high;
  - `flush_en` is low;
  - `occ[ins_seq_num[k]]` is 0;
  - no lower-indexed port with `ins_en` high targets the same seq.
- `ins_rdy[k]` equals the grant. A rejected insert is dropped, and the producer retries.
- **Bypass.** If the granted port with the lowest index has `ins_seq_num == deq_ptr` and `occ[deq_ptr]` is 0, that port's data drives the head in the same cycle.
- **Head.**
  - `deq_front_rdy` = `!flush_en && (occ[deq_ptr] || bypass)`.
  - `deq_front_data` = `data[deq_ptr]` if occupied; otherwise the bypass data; otherwise 0.
- **Commit.** `deq_front_en && deq_front_rdy` does three things:
  - clears `occ[deq_ptr]`;
  - advances `deq_ptr` by 1 (`p_depth-1` wraps to 0);
  - if the head came from bypass, the granted insert is consumed and not stored.
- **Store.** Every granted insert that is not consumed by bypass writes `data[seq]` and sets `occ[seq]`. This includes a bypass insert when `deq_front_en` is low; the entry is kept, not lost.
- `deq_front_en` while `deq_front_rdy` is low is ignored, with no state change.
- **Flush.** `flush_en` high at a clock edge:
  - clears all `occ`;
  - sets `deq_ptr` to `flush_seq_num` and `count` to 0;
  - overrides any insert or commit in the same cycle. `ins_rdy` and `deq_front_rdy` are forced low that cycle.
- **Count.** `count_next` = `count` + stored inserts − (1 if an occupied head was committed). It never exceeds `p_depth`.

## Timing

- Reset (`rst` low, asynchronous):
  - `occ` = 0, `deq_ptr` = 0, `count` = 0 immediately.
  - Outputs: `ins_rdy` = 0, `deq_front_rdy` = 0, `deq_front_data` = 0, `deq_front_seq_num` = 0.
  - Deassertion is synchronised by the environment. The first active edge may accept inserts.
- `ins_rdy`, `deq_front_rdy`, and `deq_front_data` are combinational from the current inputs and state, with no registered outputs.
- Stored insert to head: visible 1 cycle after acceptance. Bypass insert to head: 0 cycles.
- Commit throughput: 1 per cycle. Insert throughput: up to `p_num_ins` per cycle to distinct free slots.
- Same-cycle commit of slot *s* and insert to *s*: the insert is rejected, because `occ[s]` is still 1 in that cycle. It may retry next cycle.
- Full (`count == p_depth`): every insert is rejected and commit proceeds normally.
- Empty with no bypass: `deq_front_rdy` = 0.
- Reset asserted mid-operation discards all entries. The next sequence expected is 0.

## Test plan

- Reset, then insert seq 2, 1, 0 on port 0 in cycles 1–3, with `deq_front_en` held high:
  - cycle 3 bypass commits seq 0;
  - seq 1 and 2 commit in cycles 4 and 5;
  - `deq_front_seq_num` reaches 3 and `count` returns to 0.
- Ports 0 and 1 both insert seq 4 in the same cycle → `ins_rdy` = {1, 0} for ports {0, 1}, and port 0's data is the one stored.
- With `deq_front_en` low, insert seq 0 (the head) → stored, `count` = 1, head data appears without loss, and a commit next cycle empties the buffer.
- Fill all 8 slots (`p_depth` = 8) → `count` = 8; a 9th insert to an occupied slot is rejected; 8 consecutive commits wrap `deq_ptr` 0 → 7 → 0.
- With 5 entries pending, assert `flush_en` with `flush_seq_num` = 6 → `count` = 0 next cycle, `deq_front_seq_num` = 6, and a same-cycle insert is rejected.
- Drop `rst` asynchronously mid-cycle with 3 entries pending → `deq_front_rdy` and `count` go to 0 without waiting for a clock edge, and the pointer returns to 0.
